rgb_tile_encoder: RTL and testbench

// - Inverse of the RGB sorter: takes a 64-bit tile order (one 4-bit tile ID per board position) and streams out
//   the reference RGB colour of each position, one position per beat, over a valid/ready handshake.
// - Sits between the klotski game/solver state and the overlay/VGA painter, or a self-check loop back into the sorter.
// - Also checks that the order is a permutation of 0..15 (no duplicate IDs) and reports the result with done.

---
 rtl/rgb_tile_encoder.sv | 124 ++++++++++++
 tb/tb_rgb_tile_encoder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_tile_encoder.sv
// Streams the reference RGB colour of each of 16 board positions from a latched tile order, checking for duplicate IDs.
// One cycle from start to the first beat; every output is registered, and a beat holds steady while i_ready is low.
module rgb_tile_encoder #(
  parameter bit ERR_ON_DUP = 1'b1,
  parameter int N_POS      = 16,
  parameter int TILE_W     = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [N_POS*TILE_W-1:0] i_order,
  input  logic                    i_ready,
  output logic                    o_valid,
  output logic [23:0]             o_rgb,
  output logic [TILE_W-1:0]       o_pos,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err
);

  localparam logic [TILE_W-1:0] LAST_POS = TILE_W'(N_POS - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

  state_t                  r_state;
  logic [N_POS*TILE_W-1:0] r_order;
  logic [TILE_W-1:0]       r_pos;
  logic [N_POS-1:0]        r_seen;
  logic                    r_dup;

  logic                    w_accept;
  logic [TILE_W-1:0]       w_id;
  logic [TILE_W-1:0]       w_pos_nxt;
  logic [TILE_W-1:0]       w_id_nxt;
  logic                    w_dup_now;

  function automatic logic [23:0] f_palette(input logic [TILE_W-1:0] id);
    logic [23:0] rgb;
    rgb = 24'h000000;
    case (id)
      4'd0:  rgb = 24'hff7fff;
      4'd1:  rgb = 24'hffffff;
      4'd2:  rgb = 24'hffff00;
      4'd3:  rgb = 24'hff7f00;
      4'd4:  rgb = 24'hff007f;
      4'd5:  rgb = 24'hff0000;
      4'd6:  rgb = 24'h7fff7f;
      4'd7:  rgb = 24'h7f7f00;
      4'd8:  rgb = 24'h7f00ff;
      4'd9:  rgb = 24'h7f0000;
      4'd10: rgb = 24'h00ffff;
      4'd11: rgb = 24'h00ff00;
      4'd12: rgb = 24'h007fff;
      4'd13: rgb = 24'h007f00;
      4'd14: rgb = 24'h00007f;
      4'd15: rgb = 24'h000000;
      default: rgb = 24'h000000;
    endcase
    return rgb;
  endfunction

  assign w_accept  = o_valid & i_ready;
  assign w_id      = r_order[{r_pos, 2'b00} +: TILE_W];
  assign w_pos_nxt = r_pos + 1'b1;
  assign w_id_nxt  = r_order[{w_pos_nxt, 2'b00} +: TILE_W];
  assign w_dup_now = r_seen[w_id];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_order <= '0;
      r_pos   <= '0;
      r_seen  <= '0;
      r_dup   <= 1'b0;
      o_valid <= 1'b0;
      o_rgb   <= '0;
      o_pos   <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_order <= i_order;
            r_pos   <= '0;
            r_seen  <= '0;
            r_dup   <= 1'b0;
            o_err   <= 1'b0;
            o_valid <= 1'b1;
            o_pos   <= '0;
            o_rgb   <= f_palette(i_order[TILE_W-1:0]);
            o_busy  <= 1'b1;
            r_state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_accept) begin
            r_seen[w_id] <= 1'b1;
            r_dup        <= r_dup | w_dup_now;
            // The final beat's own duplicate must reach o_err on the same edge.
            if (r_pos == LAST_POS) begin
              o_valid <= 1'b0;
              o_done  <= 1'b1;
              o_err   <= (r_dup | w_dup_now) & ERR_ON_DUP;
              r_state <= S_DONE;
            end else begin
              r_pos <= w_pos_nxt;
              o_pos <= w_pos_nxt;
              o_rgb <= f_palette(w_id_nxt);
            end
          end
        end
        S_DONE: begin
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_tile_encoder.sv
// Scoreboard bench for rgb_tile_encoder: random and directed tile orders against a palette/permutation model.
module tb_rgb_tile_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        ready = 1'b0;
  logic [63:0] order = '0;

  logic        valid, busy, done, err;
  logic [23:0] rgb;
  logic [3:0]  pos;
  logic        valid0, busy0, done0, err0;
  logic [23:0] rgb0;
  logic [3:0]  pos0;

  rgb_tile_encoder #(.ERR_ON_DUP(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_order(order), .i_ready(ready),
    .o_valid(valid), .o_rgb(rgb), .o_pos(pos), .o_busy(busy), .o_done(done), .o_err(err)
  );

  rgb_tile_encoder #(.ERR_ON_DUP(1'b0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_order(order), .i_ready(ready),
    .o_valid(valid0), .o_rgb(rgb0), .o_pos(pos0), .o_busy(busy0), .o_done(done0), .o_err(err0)
  );

  always #5 clk = ~clk;

  logic [23:0] pal [16] = '{24'hff7fff, 24'hffffff, 24'hffff00, 24'hff7f00,
                            24'hff007f, 24'hff0000, 24'h7fff7f, 24'h7f7f00,
                            24'h7f00ff, 24'h7f0000, 24'h00ffff, 24'h00ff00,
                            24'h007fff, 24'h007f00, 24'h00007f, 24'h000000};

  typedef struct packed {
    logic [3:0]  pos;
    logic [23:0] rgb;
  } beat_t;

  beat_t exp_q[$];
  bit    done_q[$];
  int    checks = 0;
  int    failures = 0;
  int    beat_cnt = 0;
  int    done_cnt = 0;
  int    rdy_mode = 0;
  bit    held_vld = 0;
  beat_t held;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       ready = 1'b1;
      1:       ready = ~ready;
      default: ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pops the scoreboard on every accepted beat and on every done pulse.
  always @(negedge clk) begin
    beat_t e;
    bit    de;
    if (rst_n) begin
      if (valid) begin
        chk("busy_while_valid", busy, 1);
        if (held_vld) begin
          chk("hold_pos", pos, held.pos);
          chk("hold_rgb", rgb, held.rgb);
        end
        if (ready) begin
          chk("beat_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("beat_pos", pos, e.pos);
            chk("beat_rgb", rgb, e.rgb);
          end
          beat_cnt++;
          held_vld = 0;
        end else begin
          held_vld = 1;
          held.pos = pos;
          held.rgb = rgb;
        end
      end else begin
        held_vld = 0;
      end
      if (done) begin
        done_cnt++;
        chk("done_valid_low", valid, 0);
        chk("done_both_inst", done0, 1);
        chk("done_expected", done_q.size() > 0, 1);
        chk("done_beats_left", exp_q.size(), 0);
        if (done_q.size() > 0) begin
          de = done_q.pop_front();
          chk("err_at_done", err, de);
          chk("err_at_done_nodup_param", err0, 0);
        end
      end
    end
  end

  task automatic run_frame(input logic [63:0] ord, input int mode, input int restart_at,
                           input int reset_at);
    int cnt[16];
    bit dup;
    int cyc;
    int d0;
    bit restarted;
    dup = 0;
    restarted = 0;
    for (int i = 0; i < 16; i++) cnt[i] = 0;
    for (int p = 0; p < 16; p++) begin
      int id;
      id = int'(ord[4*p +: 4]);
      cnt[id]++;
      exp_q.push_back(beat_t'{pos: 4'(p), rgb: pal[id]});
    end
    for (int i = 0; i < 16; i++) if (cnt[i] > 1) dup = 1;
    if (reset_at < 0) done_q.push_back(dup);

    @(posedge clk); #2;
    rdy_mode = mode;
    start = 1'b1;
    order = ord;
    d0 = done_cnt;
    beat_cnt = 0;
    @(posedge clk); #2;
    start = 1'b0;
    order = {$urandom, $urandom};
    @(negedge clk); #1;
    chk("start_latency_valid", valid, 1);
    chk("start_latency_pos", pos, 0);
    chk("err_clear_on_start", err, 0);
    cyc = 1;
    while (done_cnt == d0 && cyc < 400) begin
      if (start) start = 1'b0;
      if (restart_at >= 0 && !restarted && beat_cnt >= restart_at) begin
        start = 1'b1;
        order = {$urandom, $urandom};
        restarted = 1;
      end
      if (reset_at >= 0 && beat_cnt >= reset_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pos", pos, 0);
        chk("rst_done", done, 0);
        chk("rst_valid_inst0", valid0, 0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("no_done_after_abort", done_cnt, d0);
        return;
      end
      @(negedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk("done_seen_in_budget", done_cnt != d0, 1);
    if (mode == 0) chk("throughput_cycles", cyc, 17);
    repeat (3) @(negedge clk);
    #1;
    chk("single_done", done_cnt - d0, 1);
    chk("idle_busy", busy, 0);
    chk("idle_err_held", err, dup);
    chk("idle_err_inst0", err0, 0);
  endtask

  function automatic logic [63:0] rand_perm(input bit make_dup);
    int a[16];
    logic [63:0] r;
    for (int i = 0; i < 16; i++) a[i] = i;
    for (int i = 15; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(0, i));
      t = a[i]; a[i] = a[j]; a[j] = t;
    end
    if (make_dup) a[$urandom_range(0, 15)] = a[$urandom_range(0, 15)];
    for (int i = 0; i < 16; i++) r[4*i +: 4] = 4'(a[i]);
    return r;
  endfunction

  initial begin
    #12;
    chk("reset_valid", valid, 0);
    chk("reset_rgb", rgb, 0);
    chk("reset_pos", pos, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_frame(64'h9537_1fbd_2648_0eac, 0, -1, -1);
    run_frame(64'h9537_1fbd_2648_0eac, 1, -1, -1);
    run_frame(64'h0, 2, -1, -1);
    run_frame(64'hfedc_ba98_7654_3210, 0, -1, -1);
    run_frame(64'hfedc_ba98_7654_3211, 2, -1, -1);
    run_frame(64'h9537_1fbd_2648_0eac, 0, 5, -1);
    run_frame(64'h9537_1fbd_2648_0eac, 0, -1, 7);
    run_frame(64'h9537_1fbd_2648_0eac, 0, -1, -1);
    for (int k = 0; k < 8; k++) run_frame(rand_perm(k[0]), 2, -1, -1);
    for (int k = 0; k < 4; k++) run_frame({$urandom, $urandom}, 2, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
